// File: rtl/knn_sched.sv
// knn_sched: sequencer for the KNN distance datapath.
// Streams n_points {label, x, y} records from the point memory. It computes
// the squared Euclidean distance of each record to a latched test point and
// keeps a sorted list of the K nearest records. Ties keep the earlier record
// nearer.
// Optional feature: define KNN_VOTE_EN to add a majority vote over the kept
// labels. The vote takes K extra cycles before done.
`timescale 1ns/1ps
module knn_sched #(
  parameter int COORD_W = 16,
  parameter int LABEL_W = 8,
  parameter int ADDR_W  = 10,
  parameter int K       = 4,
  localparam int DIST_W = 2*COORD_W+3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             n_points,
  input  logic signed [COORD_W-1:0]     test_x,
  input  logic signed [COORD_W-1:0]     test_y,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [LABEL_W+2*COORD_W-1:0]  mem_rdata,
  output logic [K*LABEL_W-1:0]          knn_label,
  output logic [K*DIST_W-1:0]           knn_dist,
  output logic [3:0]                    knn_count
`ifdef KNN_VOTE_EN
  ,
  output logic [LABEL_W-1:0]            vote_label,
  output logic                          vote_valid
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_INSERT,
`ifdef KNN_VOTE_EN
    S_VOTE,
`endif
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Search context latched on start
  logic signed [COORD_W-1:0] tx_q, ty_q;
  logic [ADDR_W-1:0]         n_q;
  logic [ADDR_W-1:0]         index_q;
  logic [ADDR_W-1:0]         index_next;
  logic                      index_last;

  // Record under evaluation
  logic [LABEL_W-1:0]        rec_label_q;
  logic [DIST_W-1:0]         dist_q;

  // Sorted neighbour list; entry 0 is the nearest
  logic [LABEL_W-1:0]        lbl_q [K];
  logic [DIST_W-1:0]         dst_q [K];
  logic [3:0]                count_q;

  // Insertion results
  logic [LABEL_W-1:0]        lbl_d [K];
  logic [DIST_W-1:0]         dst_d [K];
  logic [3:0]                count_next;
  int                        ins_pos;

  // Distance datapath
  logic [COORD_W-1:0]              rec_x, rec_y;
  logic signed [2*COORD_W+1:0]     dx_w, dy_w;
  logic [2*COORD_W+1:0]            sq_x, sq_y;
  logic [DIST_W-1:0]               dist_calc;

`ifdef KNN_VOTE_EN
  logic [3:0]                vote_idx_q;
  logic [3:0]                best_cnt_q;
  logic [LABEL_W-1:0]        best_label_q;
  logic [LABEL_W-1:0]        vote_sel;
  logic [3:0]                vote_match;
`endif

  assign index_next = index_q + ADDR_W'(1);
  assign index_last = (index_next == n_q);
  assign count_next = (count_q == 4'(K)) ? count_q : count_q + 4'd1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (n_points == '0) ? S_DONE : S_FETCH;
      S_FETCH:  state_d = S_CALC;
      S_CALC:   state_d = S_INSERT;
      S_INSERT: begin
        if (index_last) begin
`ifdef KNN_VOTE_EN
          state_d = S_VOTE;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_FETCH;
        end
      end
`ifdef KNN_VOTE_EN
      S_VOTE:   if (vote_idx_q == 4'(K-1)) state_d = S_DONE;
`endif
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Squared distance of the record on mem_rdata to the test point
  always_comb begin
    rec_x     = mem_rdata[2*COORD_W-1:COORD_W];
    rec_y     = mem_rdata[COORD_W-1:0];
    // Differences need COORD_W+1 bits; widen before multiplying so the
    // signed product is exact.
    dx_w      = (2*COORD_W+2)'($signed({rec_x[COORD_W-1], rec_x}) - $signed({tx_q[COORD_W-1], tx_q}));
    dy_w      = (2*COORD_W+2)'($signed({rec_y[COORD_W-1], rec_y}) - $signed({ty_q[COORD_W-1], ty_q}));
    sq_x      = $unsigned(dx_w * dx_w);
    sq_y      = $unsigned(dy_w * dy_w);
    dist_calc = {1'b0, sq_x} + {1'b0, sq_y};
  end

  // Sorted insertion: first slot whose entry is invalid or strictly farther
  always_comb begin
    ins_pos = K;
    for (int p = K-1; p >= 0; p--) begin
      if (p >= int'(count_q) || dist_q < dst_q[p]) ins_pos = p;
    end
    for (int i = 0; i < K; i++) begin
      lbl_d[i] = lbl_q[i];
      dst_d[i] = dst_q[i];
    end
    for (int i = 1; i < K; i++) begin
      if (i > ins_pos) begin
        lbl_d[i] = lbl_q[i-1];
        dst_d[i] = dst_q[i-1];
      end
    end
    for (int i = 0; i < K; i++) begin
      if (i == ins_pos) begin
        lbl_d[i] = rec_label_q;
        dst_d[i] = dist_q;
      end
    end
  end

`ifdef KNN_VOTE_EN
  // Label of the entry under vote and how many valid entries share it
  always_comb begin
    vote_sel   = '0;
    vote_match = '0;
    for (int j = 0; j < K; j++) begin
      if (4'(j) == vote_idx_q) vote_sel = lbl_q[j];
    end
    for (int i = 0; i < K; i++) begin
      if (i < int'(count_q) && lbl_q[i] == vote_sel) vote_match = vote_match + 4'd1;
    end
  end
`endif

  // Datapath, list and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      n_q         <= '0;
      index_q     <= '0;
      rec_label_q <= '0;
      dist_q      <= '0;
      count_q     <= '0;
      // NOTE: the list is a small register file, not RAM, and software may
      // read it straight after reset, so every entry gets a reset value.
      for (int i = 0; i < K; i++) begin
        lbl_q[i] <= '0;
        dst_q[i] <= '1;
      end
`ifdef KNN_VOTE_EN
      vote_idx_q   <= '0;
      best_cnt_q   <= '0;
      best_label_q <= '0;
      vote_label   <= '0;
      vote_valid   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout, so every register here sees pre-edge values.
      busy   <= (state_d != S_IDLE);
      done   <= (state_d == S_DONE);
      mem_en <= (state_d == S_FETCH);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tx_q    <= test_x;
            ty_q    <= test_y;
            n_q     <= n_points;
            index_q <= '0;
            count_q <= '0;
            for (int i = 0; i < K; i++) begin
              lbl_q[i] <= '0;
              dst_q[i] <= '1;
            end
            // Address only moves when a fetch follows
            if (n_points != '0) mem_addr <= '0;
`ifdef KNN_VOTE_EN
            vote_idx_q   <= '0;
            best_cnt_q   <= '0;
            best_label_q <= '0;
            vote_label   <= '0;
            vote_valid   <= 1'b0;
`endif
          end
        end
        S_CALC: begin
          rec_label_q <= mem_rdata[LABEL_W+2*COORD_W-1:2*COORD_W];
          dist_q      <= dist_calc;
        end
        S_INSERT: begin
          for (int i = 0; i < K; i++) begin
            lbl_q[i] <= lbl_d[i];
            dst_q[i] <= dst_d[i];
          end
          count_q <= count_next;
          index_q <= index_next;
          if (!index_last) mem_addr <= index_next;
        end
`ifdef KNN_VOTE_EN
        S_VOTE: begin
          // Strictly greater keeps the nearer entry on equal counts
          if (int'(vote_idx_q) < int'(count_q) && vote_match > best_cnt_q) begin
            best_cnt_q   <= vote_match;
            best_label_q <= vote_sel;
          end
          vote_idx_q <= vote_idx_q + 4'd1;
        end
        S_DONE: begin
          vote_valid <= (count_q != '0);
          vote_label <= (count_q != '0) ? best_label_q : '0;
        end
`endif
        default: ;
      endcase
    end
  end

  // Flatten the list onto the result ports, entry 0 in the LSBs
  for (genvar g = 0; g < K; g++) begin : g_out
    assign knn_label[g*LABEL_W +: LABEL_W] = lbl_q[g];
    assign knn_dist[g*DIST_W +: DIST_W]    = dst_q[g];
  end
  assign knn_count = count_q;

endmodule

// File: tb/tb_knn_sched.sv
// tb_knn_sched: randomized and directed bench for knn_sched.
// A driver issues searches and pushes the expected results, which come from a
// sort-based reference model, into a scoreboard queue. A monitor pops and
// compares on every done pulse. It also checks the read-address sequence and
// its timing.
// Define KNN_VOTE_EN to build against the vote variant.
`timescale 1ns/1ps
module tb_knn_sched;

  localparam int COORD_W = 16;
  localparam int LABEL_W = 8;
  localparam int ADDR_W  = 10;
  localparam int K       = 4;
  localparam int DIST_W  = 2*COORD_W+3;
  localparam int REC_W   = LABEL_W+2*COORD_W;
`ifdef KNN_VOTE_EN
  localparam int VOTE_LAT = K;
`else
  localparam int VOTE_LAT = 0;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       start;
  logic [ADDR_W-1:0]          n_points;
  logic signed [COORD_W-1:0]  test_x, test_y;
  logic                       busy, done, mem_en;
  logic [ADDR_W-1:0]          mem_addr;
  logic [REC_W-1:0]           mem_rdata;
  logic [K*LABEL_W-1:0]       knn_label;
  logic [K*DIST_W-1:0]        knn_dist;
  logic [3:0]                 knn_count;
`ifdef KNN_VOTE_EN
  logic [LABEL_W-1:0]         vote_label;
  logic                       vote_valid;
`endif

  knn_sched #(.COORD_W(COORD_W), .LABEL_W(LABEL_W), .ADDR_W(ADDR_W), .K(K)) dut (
    .clk(clk), .rst(rst_n), .start(start), .n_points(n_points),
    .test_x(test_x), .test_y(test_y), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .knn_label(knn_label), .knn_dist(knn_dist), .knn_count(knn_count)
`ifdef KNN_VOTE_EN
    , .vote_label(vote_label), .vote_valid(vote_valid)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Training-point memory model: one cycle read latency
  int rec_l [1024];
  int rec_x [1024];
  int rec_y [1024];
  always @(posedge clk) begin
    if (mem_en)
      mem_rdata <= {LABEL_W'(rec_l[mem_addr]), COORD_W'(rec_x[mem_addr]), COORD_W'(rec_y[mem_addr])};
  end

  typedef struct {
    logic [K*LABEL_W-1:0] lbl;
    logic [K*DIST_W-1:0]  dst;
    int                   cnt;
    int                   lat;
    int                   vlabel;
    int                   vvalid;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  bit   have_last = 0;
  int   tests = 0;
  int   fails = 0;
  int   done_count = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: all distances, then pick the K smallest by (distance, index)
  task automatic model(input int n, input int tx, input int ty, output exp_t e);
    longint d [1024];
    bit     used [1024];
    int     lab [K];
    int     best, bc;
    e.lbl = '0;
    e.dst = '1;
    e.cnt = (n < K) ? n : K;
    for (int i = 0; i < n; i++) begin
      longint dx, dy;
      dx = longint'(rec_x[i]) - longint'(tx);
      dy = longint'(rec_y[i]) - longint'(ty);
      d[i] = dx*dx + dy*dy;
      used[i] = 1'b0;
    end
    for (int k = 0; k < e.cnt; k++) begin
      best = -1;
      for (int i = 0; i < n; i++)
        if (!used[i] && (best < 0 || d[i] < d[best])) best = i;
      used[best] = 1'b1;
      lab[k] = rec_l[best];
      e.lbl[k*LABEL_W +: LABEL_W] = LABEL_W'(rec_l[best]);
      e.dst[k*DIST_W +: DIST_W]   = DIST_W'(d[best]);
    end
    e.vlabel = 0;
    e.vvalid = (e.cnt > 0) ? 1 : 0;
    bc = 0;
    for (int j = 0; j < e.cnt; j++) begin
      int c = 0;
      for (int i = 0; i < e.cnt; i++) if (lab[i] == lab[j]) c++;
      if (c > bc) begin bc = c; e.vlabel = lab[j]; end
    end
    e.lat = 3*n + 1 + ((n > 0) ? VOTE_LAT : 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_addr"},   mem_addr, 0);
    check({tag, "_count"},  knn_count, 0);
    check({tag, "_label"},  knn_label, 0);
    check({tag, "_dist"},   knn_dist, {(K*DIST_W){1'b1}});
`ifdef KNN_VOTE_EN
    check({tag, "_vlabel"}, vote_label, 0);
    check({tag, "_vvalid"}, vote_valid, 0);
`endif
  endtask

  // Monitor: address stream, latency and scoreboard comparison
  initial begin
    bit busy_prev = 0, done_prev = 0;
    int run_start = 0, rd_idx = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_prev = 0;
        done_prev = 0;
      end else begin
        if (busy && !busy_prev) begin
          run_start = cyc - 1;
          rd_idx = 0;
        end
        if (done_prev) check("busy_after_done", busy, 0);
        if (mem_en) begin
          check("mem_addr", mem_addr, rd_idx);
          check("fetch_cycle", cyc - run_start, 3*rd_idx + 1);
          rd_idx++;
        end
        if (done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("busy_at_done", busy, 1);
            check("done_cycle", cyc - run_start, e.lat);
            check("knn_label", knn_label, e.lbl);
            check("knn_dist", knn_dist, e.dst);
            check("knn_count", knn_count, e.cnt);
`ifdef KNN_VOTE_EN
            // Vote outputs update one cycle after done; checked by the driver hold check
`endif
          end
          done_count++;
        end
        busy_prev = busy;
        done_prev = done;
      end
    end
  end

  // Issue one search; glitch_at >= 0 pulses a second, ignored start that many cycles in
  task automatic run_search(input int n, input int tx, input int ty, input int glitch_at = -1);
    exp_t e;
    int dc0, w;
    if (have_last) begin
      check("hold_label", knn_label, last_exp.lbl);
      check("hold_dist",  knn_dist,  last_exp.dst);
      check("hold_count", knn_count, last_exp.cnt);
`ifdef KNN_VOTE_EN
      check("vote_valid", vote_valid, last_exp.vvalid);
      check("vote_label", vote_label, last_exp.vlabel);
`endif
    end
    model(n, tx, ty, e);
    sb_q.push_back(e);
    last_exp = e;
    have_last = 1;
    dc0 = done_count;
    @(negedge clk);
    start = 1; n_points = ADDR_W'(n); test_x = COORD_W'(tx); test_y = COORD_W'(ty);
    @(negedge clk);
    start = 0;
    if (glitch_at > 0) begin
      repeat (glitch_at - 1) @(negedge clk);
      start = 1; n_points = 3; test_x = 100; test_y = -100;
      @(negedge clk);
      start = 0;
    end
    w = 0;
    while (done_count == dc0 && w < 3*n + K + 40) begin
      @(negedge clk);
      w++;
    end
    if (done_count == dc0) check("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_rec(input int i, input int l, input int x, input int y);
    rec_l[i] = l; rec_x[i] = x; rec_y[i] = y;
  endtask

  task automatic load_test2();
    set_rec(0, 1, 3, 4);  set_rec(1, 2, 1, 1);  set_rec(2, 3, -2, 0);
    set_rec(3, 4, 10, 0); set_rec(4, 5, 0, -1); set_rec(5, 6, 2, 2);
  endtask

  initial begin
    logic [K*LABEL_W-1:0] t2_lbl;
    logic [K*DIST_W-1:0]  t2_dst;
    int t2_l [K] = '{5, 2, 3, 6};
    int t2_d [K] = '{1, 2, 4, 8};
    int s;
    rst_n = 0; start = 0; n_points = 0; test_x = 0; test_y = 0;
    for (int i = 0; i < 1024; i++) set_rec(i, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1;
    @(negedge clk);

    // Six-point example with hand-computed result
    load_test2();
    run_search(6, 0, 0);
    for (int k = 0; k < K; k++) begin
      t2_lbl[k*LABEL_W +: LABEL_W] = LABEL_W'(t2_l[k]);
      t2_dst[k*DIST_W +: DIST_W]   = DIST_W'(t2_d[k]);
    end
    check("t2_label_const", knn_label, t2_lbl);
    check("t2_dist_const",  knn_dist,  t2_dst);

    // Partially filled list
    set_rec(0, 9, 5, 5); set_rec(1, 4, 6, 7);
    run_search(2, 5, 5);

    // Equal distances keep memory order
    set_rec(0, 7, 2, 0); set_rec(1, 8, 0, 2); set_rec(2, 9, 0, -2); set_rec(3, 1, 3, 3);
    run_search(4, 0, 0);

    // Coordinate extremes
    set_rec(0, 3, -32768, -32768);
    run_search(1, 32767, 32767);
    check("extreme_dist", knn_dist[DIST_W-1:0], 35'd8589672450);

    // Empty search
    run_search(0, 0, 0);

    // Second start mid-search is ignored
    load_test2();
    run_search(6, 0, 0, 5);

    // Reset mid-search, then a clean rerun
    @(negedge clk);
    start = 1; n_points = 6; test_x = 0; test_y = 0;
    s = cyc;
    @(negedge clk);
    start = 0;
    while (cyc < s + 8) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check_reset("mid_rst");
    rst_n = 1;
    have_last = 0;
    @(negedge clk);
    run_search(6, 0, 0);
    check("rerun_label", knn_label, t2_lbl);

    // Vote data: repeated labels
    set_rec(0, 5, 3, 4);  set_rec(1, 5, 1, 1);  set_rec(2, 3, -2, 0);
    set_rec(3, 6, 10, 0); set_rec(4, 5, 0, -1); set_rec(5, 2, 2, 2);
    run_search(6, 0, 0);
    load_test2();
    run_search(6, 0, 0);

    // Randomized searches: small ranges force ties, full ranges test widths
    for (int r = 0; r < 14; r++) begin
      int n = $urandom_range(1, 20);
      bit wide = (r % 3 == 2);
      for (int i = 0; i < n; i++) begin
        if (wide) set_rec(i, $urandom_range(0, 255),
                          int'($urandom_range(0, 65535)) - 32768,
                          int'($urandom_range(0, 65535)) - 32768);
        else      set_rec(i, $urandom_range(0, 3),
                          int'($urandom_range(0, 8)) - 4,
                          int'($urandom_range(0, 8)) - 4);
      end
      if (wide) run_search(n, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      else      run_search(n, int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 4)) - 2);
    end

    // Last result still held; nothing left in the scoreboard
    repeat (5) @(negedge clk);
    check("final_hold_label", knn_label, last_exp.lbl);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
